// File: rtl/obi_mem_arbiter_2to1_pkg.sv
// Shared definitions for the two-port OBI memory arbiter: source IDs carried
// in the response-routing FIFO and default geometry.
package obi_mem_arbiter_2to1_pkg;

  // Source ID stored per granted transaction; selects which port gets rvalid.
  localparam logic OBI_SRC_IMEM = 1'b0;
  localparam logic OBI_SRC_DMEM = 1'b1;

  // Default geometry matching the cpu64 core/cache subsystem.
  localparam int OBI_ADDR_W_DEF  = 64;
  localparam int OBI_DATA_W_DEF  = 64;
  localparam int OBI_MAX_OUT_DEF = 4;

  // The round-robin pointer only ever names one of two ports.
  function automatic logic obi_other_src(input logic src);
    return ~src;
  endfunction

endpackage

// File: rtl/obi_id_fifo.sv
// 1-bit-wide in-order FIFO holding the source ID of every granted but not yet
// answered transaction. The head is visible combinationally so a response
// can be routed in the same cycle it arrives. A push while full is accepted
// only when a pop happens in the same cycle; a pop while empty is ignored.
module obi_id_fifo
  import obi_mem_arbiter_2to1_pkg::*;
#(
  parameter int DEPTH = OBI_MAX_OUT_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   data_i,
  output logic                   head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic             mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_FULL);
  assign do_pop  = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot the push is about to use.
  assign do_push = push_i & (~full_o | do_pop);
  assign head_o  = mem_q[rptr_q];
  assign count_o = cnt_q;

  // Next pointers and occupancy; pointers wrap naturally (DEPTH is a power of 2).
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = wptr_q + PTR_ONE;
    if (do_pop)  rptr_d = rptr_q + PTR_ONE;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and count registers; reset discards every in-flight ID.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // ID storage; contents are meaningless while empty so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/obi_mem_arbiter_2to1.sv
// Merges the instruction-side and data-side OBI ports of the cpu64 core onto
// one OBI master toward a single-ported memory. Address phases are arbitrated
// round-robin with request locking; responses are routed back in grant order
// through a source-ID FIFO. All request/grant/response paths are combinational.
module obi_mem_arbiter_2to1
  import obi_mem_arbiter_2to1_pkg::*;
#(
  parameter int ADDR_W          = OBI_ADDR_W_DEF,
  parameter int DATA_W          = OBI_DATA_W_DEF,
  parameter int MAX_OUTSTANDING = OBI_MAX_OUT_DEF
) (
  input  logic                               clk,
  input  logic                               rst_n,
  // instruction side
  input  logic                               i_req_i,
  input  logic                               i_we_i,
  input  logic [DATA_W/8-1:0]                i_be_i,
  input  logic [ADDR_W-1:0]                  i_addr_i,
  input  logic [DATA_W-1:0]                  i_wdata_i,
  output logic                               i_gnt_o,
  output logic                               i_rvalid_o,
  output logic [DATA_W-1:0]                  i_rdata_o,
  // data side
  input  logic                               d_req_i,
  input  logic                               d_we_i,
  input  logic [DATA_W/8-1:0]                d_be_i,
  input  logic [ADDR_W-1:0]                  d_addr_i,
  input  logic [DATA_W-1:0]                  d_wdata_i,
  output logic                               d_gnt_o,
  output logic                               d_rvalid_o,
  output logic [DATA_W-1:0]                  d_rdata_o,
  // memory side
  output logic                               m_req_o,
  output logic                               m_we_o,
  output logic [DATA_W/8-1:0]                m_be_o,
  output logic [ADDR_W-1:0]                  m_addr_o,
  output logic [DATA_W-1:0]                  m_wdata_o,
  input  logic                               m_gnt_i,
  input  logic                               m_rvalid_i,
  input  logic [DATA_W-1:0]                  m_rdata_i,
  // status
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
  output logic                               err_o
);

  logic rr_q, rr_d;
  logic lock_q, lock_d;
  logic lock_sel_q, lock_sel_d;
  logic err_q, err_d;

  logic sel;
  logic sel_req;
  logic handshake;
  logic resp_pop;
  logic stall;

  logic                            fifo_head;
  logic                            fifo_full;
  logic                            fifo_empty;
  logic [$clog2(MAX_OUTSTANDING):0] fifo_count;

  // Port selection: a locked request wins, otherwise the lone requester,
  // otherwise the round-robin pointer breaks the tie.
  always_comb begin
    if (lock_q) begin
      sel = lock_sel_q;
    end else if (i_req_i && !d_req_i) begin
      sel = OBI_SRC_IMEM;
    end else if (d_req_i && !i_req_i) begin
      sel = OBI_SRC_DMEM;
    end else begin
      sel = rr_q;
    end
  end

  assign sel_req  = (sel == OBI_SRC_DMEM) ? d_req_i : i_req_i;
  assign resp_pop = m_rvalid_i & ~fifo_empty;
  // A full FIFO only blocks when no response frees a slot this cycle.
  assign stall     = fifo_full & ~resp_pop;
  assign m_req_o   = sel_req & ~stall;
  assign handshake = m_req_o & m_gnt_i;

  // Address-phase payload follows the selected port.
  always_comb begin
    if (sel == OBI_SRC_DMEM) begin
      m_we_o    = d_we_i;
      m_be_o    = d_be_i;
      m_addr_o  = d_addr_i;
      m_wdata_o = d_wdata_i;
    end else begin
      m_we_o    = i_we_i;
      m_be_o    = i_be_i;
      m_addr_o  = i_addr_i;
      m_wdata_o = i_wdata_i;
    end
  end

  // Grants are forced low while in reset regardless of the memory's gnt.
  assign i_gnt_o = rst_n & handshake & (sel == OBI_SRC_IMEM);
  assign d_gnt_o = rst_n & handshake & (sel == OBI_SRC_DMEM);

  // Responses go to the port at the FIFO head; data is broadcast to both.
  assign i_rvalid_o = resp_pop & (fifo_head == OBI_SRC_IMEM);
  assign d_rvalid_o = resp_pop & (fifo_head == OBI_SRC_DMEM);
  assign i_rdata_o  = m_rdata_i;
  assign d_rdata_o  = m_rdata_i;

  assign outstanding_o = fifo_count;
  assign err_o         = err_q;

  // Next arbitration state: pointer toggles per handshake, lock holds an
  // un-granted request, error latches on a response with nothing outstanding.
  always_comb begin
    rr_d       = rr_q;
    if (handshake) rr_d = obi_other_src(rr_q);
    lock_d     = m_req_o & ~m_gnt_i;
    lock_sel_d = sel;
    err_d      = err_q | (m_rvalid_i & fifo_empty);
  end

  // Arbitration and error state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q       <= OBI_SRC_IMEM;
      lock_q     <= 1'b0;
      lock_sel_q <= OBI_SRC_IMEM;
      err_q      <= 1'b0;
    end else begin
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_sel_q <= lock_sel_d;
      err_q      <= err_d;
    end
  end

  obi_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (handshake),
    .pop_i   (m_rvalid_i),
    .data_i  (sel),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

endmodule

// File: tb/tb_obi_mem_arbiter_2to1.sv
// Randomised bench for the 2:1 OBI arbiter. A behavioural model (queue of
// source IDs plus round-robin/lock bookkeeping) predicts every output each
// cycle; directed phases steer the random knobs toward the notable cases.
module tb_obi_mem_arbiter_2to1;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int BW = DW / 8;
  localparam int MO = 4;
  localparam int CW = $clog2(MO) + 1;

  logic          clk;
  logic          rst_n;
  logic          i_req_i, i_we_i, d_req_i, d_we_i;
  logic [BW-1:0] i_be_i, d_be_i;
  logic [AW-1:0] i_addr_i, d_addr_i;
  logic [DW-1:0] i_wdata_i, d_wdata_i;
  logic          i_gnt_o, i_rvalid_o, d_gnt_o, d_rvalid_o;
  logic [DW-1:0] i_rdata_o, d_rdata_o;
  logic          m_req_o, m_we_o;
  logic [BW-1:0] m_be_o;
  logic [AW-1:0] m_addr_o;
  logic [DW-1:0] m_wdata_o;
  logic          m_gnt_i, m_rvalid_i;
  logic [DW-1:0] m_rdata_i;
  logic [CW-1:0] outstanding_o;
  logic          err_o;

  obi_mem_arbiter_2to1 #(
    .ADDR_W (AW), .DATA_W (DW), .MAX_OUTSTANDING (MO)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .i_req_i (i_req_i), .i_we_i (i_we_i), .i_be_i (i_be_i), .i_addr_i (i_addr_i),
    .i_wdata_i (i_wdata_i), .i_gnt_o (i_gnt_o), .i_rvalid_o (i_rvalid_o), .i_rdata_o (i_rdata_o),
    .d_req_i (d_req_i), .d_we_i (d_we_i), .d_be_i (d_be_i), .d_addr_i (d_addr_i),
    .d_wdata_i (d_wdata_i), .d_gnt_o (d_gnt_o), .d_rvalid_o (d_rvalid_o), .d_rdata_o (d_rdata_o),
    .m_req_o (m_req_o), .m_we_o (m_we_o), .m_be_o (m_be_o), .m_addr_o (m_addr_o),
    .m_wdata_o (m_wdata_o), .m_gnt_i (m_gnt_i), .m_rvalid_i (m_rvalid_i), .m_rdata_i (m_rdata_i),
    .outstanding_o (outstanding_o), .err_o (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: IDs of granted-but-unanswered transactions in order.
  bit mq[$];
  bit rr_m, lock_m, lsel_m, err_m;

  // Stimulus knobs (percent) and per-port "request held until granted" flags.
  int p_i, p_d, p_gnt, p_rv;
  bit spur;
  bit i_pend, d_pend;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    rr_m = 1'b0; lock_m = 1'b0; lsel_m = 1'b0; err_m = 1'b0;
    i_pend = 1'b0; d_pend = 1'b0;
  endtask

  // New requests only when the port is idle; a pending request keeps its payload.
  task automatic drive_inputs();
    if (!i_pend && ($urandom_range(99) < p_i)) begin
      i_pend = 1'b1;
      i_we_i = 1'($urandom); i_be_i = 8'($urandom);
      i_addr_i = {$urandom, $urandom}; i_wdata_i = {$urandom, $urandom};
    end
    if (!d_pend && ($urandom_range(99) < p_d)) begin
      d_pend = 1'b1;
      d_we_i = 1'($urandom); d_be_i = 8'($urandom);
      d_addr_i = {$urandom, $urandom}; d_wdata_i = {$urandom, $urandom};
    end
    i_req_i    = i_pend;
    d_req_i    = d_pend;
    m_gnt_i    = ($urandom_range(99) < p_gnt);
    m_rvalid_i = spur || ((mq.size() > 0) && ($urandom_range(99) < p_rv));
    m_rdata_i  = {$urandom, $urandom};
  endtask

  // Compare all outputs with the model's prediction, then advance the model.
  task automatic check_cycle();
    bit sel, popx, stall, reqx, hs, head;
    if (lock_m)                   sel = lsel_m;
    else if (i_req_i && !d_req_i) sel = 1'b0;
    else if (d_req_i && !i_req_i) sel = 1'b1;
    else                          sel = rr_m;
    popx  = m_rvalid_i && (mq.size() > 0);
    head  = popx ? mq[0] : 1'b0;
    stall = (mq.size() == MO) && !popx;
    reqx  = (sel ? d_req_i : i_req_i) && !stall;
    hs    = reqx && m_gnt_i;

    check("m_req", 64'(m_req_o), 64'(reqx));
    if (reqx) begin
      check("m_addr",  m_addr_o,         sel ? d_addr_i : i_addr_i);
      check("m_wdata", m_wdata_o,        sel ? d_wdata_i : i_wdata_i);
      check("m_be",    64'(m_be_o),      64'(sel ? d_be_i : i_be_i));
      check("m_we",    64'(m_we_o),      64'(sel ? d_we_i : i_we_i));
    end
    check("i_gnt",    64'(i_gnt_o),    64'(hs && !sel));
    check("d_gnt",    64'(d_gnt_o),    64'(hs && sel));
    check("i_rvalid", 64'(i_rvalid_o), 64'(popx && !head));
    check("d_rvalid", 64'(d_rvalid_o), 64'(popx && head));
    if (popx) begin
      check("i_rdata", i_rdata_o, m_rdata_i);
      check("d_rdata", d_rdata_o, m_rdata_i);
    end
    check("outstanding", 64'(outstanding_o), 64'(mq.size()));
    check("err",         64'(err_o),         64'(err_m));

    if (m_rvalid_i && (mq.size() == 0)) err_m = 1'b1;
    if (popx) void'(mq.pop_front());
    if (hs) begin
      mq.push_back(sel);
      rr_m = !rr_m;
      if (sel) d_pend = 1'b0; else i_pend = 1'b0;
    end
    lock_m = reqx && !m_gnt_i;
    lsel_m = sel;
  endtask

  task automatic run_cycle();
    @(posedge clk);
    #1;
    drive_inputs();
    @(negedge clk);
    cyc++;
    check_cycle();
  endtask

  task automatic run_n(input int n);
    for (int k = 0; k < n; k++) run_cycle();
  endtask

  task automatic set_knobs(input int pi, input int pd, input int pg, input int pr);
    p_i = pi; p_d = pd; p_gnt = pg; p_rv = pr;
  endtask

  // Stop issuing, grant and answer everything, then confirm the DUT is empty.
  task automatic drain();
    int k;
    k = 0;
    set_knobs(0, 0, 100, 100);
    while ((mq.size() != 0 || i_pend || d_pend) && k < 60) begin
      run_cycle();
      k++;
    end
    run_cycle();
    check("drain_empty", 64'(outstanding_o), 64'd0);
  endtask

  initial begin
    spur = 1'b0;
    set_knobs(0, 0, 0, 0);
    model_reset();

    // Reset with every input active: grants/rvalid low, m_req follows inputs.
    rst_n = 1'b0;
    i_req_i = 1'b1; d_req_i = 1'b1; m_gnt_i = 1'b1; m_rvalid_i = 1'b1;
    i_we_i = 1'b0; d_we_i = 1'b1; i_be_i = 8'hFF; d_be_i = 8'h0F;
    i_addr_i = 64'h1000; d_addr_i = 64'h2000;
    i_wdata_i = 64'h1111; d_wdata_i = 64'h2222; m_rdata_i = 64'hABCD;
    #12;
    check("rst_m_req",    64'(m_req_o),       64'd1);
    check("rst_m_addr",   m_addr_o,           64'h1000);
    check("rst_i_gnt",    64'(i_gnt_o),       64'd0);
    check("rst_d_gnt",    64'(d_gnt_o),       64'd0);
    check("rst_i_rvalid", 64'(i_rvalid_o),    64'd0);
    check("rst_d_rvalid", 64'(d_rvalid_o),    64'd0);
    check("rst_out",      64'(outstanding_o), 64'd0);
    check("rst_err",      64'(err_o),         64'd0);
    @(negedge clk);
    i_req_i = 1'b0; d_req_i = 1'b0; m_gnt_i = 1'b0; m_rvalid_i = 1'b0;
    rst_n = 1'b1;

    // I-only stream, memory withholds responses: fills to MO then stalls,
    // then responses let a new grant through in the pop cycle.
    set_knobs(100, 0, 100, 0);
    run_n(8);
    check("full_out", 64'(outstanding_o), 64'(MO));
    set_knobs(100, 0, 100, 100);
    run_n(6);
    drain();

    // Both ports request every cycle, memory always ready: strict alternation.
    set_knobs(100, 100, 100, 100);
    run_n(20);
    drain();

    // D request held without grant; I rises in cycle 2; lock keeps D selected.
    set_knobs(0, 100, 0, 0);
    run_cycle();
    set_knobs(100, 0, 0, 0);
    run_n(4);
    check("lock_addr_d", m_addr_o, d_addr_i);
    set_knobs(0, 0, 100, 0);
    run_n(3);
    drain();

    // Spurious response with nothing outstanding: dropped, error sticks.
    spur = 1'b1;
    run_cycle();
    spur = 1'b0;
    run_n(3);
    check("err_sticky", 64'(err_o), 64'd1);

    // Random traffic: balanced, then slow memory to exercise full/stall often.
    set_knobs(60, 60, 60, 40);
    run_n(300);
    set_knobs(80, 80, 70, 15);
    run_n(200);
    drain();

    // Three outstanding then asynchronous reset mid-cycle.
    set_knobs(100, 0, 100, 0);
    run_n(3);
    @(posedge clk);
    #1;
    check("pre_rst_out", 64'(outstanding_o), 64'd3);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_out",   64'(outstanding_o), 64'd0);
    check("arst_err",   64'(err_o),         64'd0);
    check("arst_i_gnt", 64'(i_gnt_o),       64'd0);
    model_reset();
    i_req_i = 1'b0; d_req_i = 1'b0; m_rvalid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // After release, both request: I-side wins first.
    set_knobs(100, 100, 100, 100);
    run_cycle();
    check("post_rst_i_gnt", 64'(i_gnt_o), 64'd1);
    check("post_rst_d_gnt", 64'(d_gnt_o), 64'd0);
    run_n(10);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1);
  end

endmodule
